// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and op-classification helpers used by the decoder and datapath.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;
  localparam logic [3:0] MD_MTHI  = 4'd9;
  localparam logic [3:0] MD_MTLO  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT)  || (op == MD_MULTU) ||
           (op == MD_MADD)  || (op == MD_MADDU) ||
           (op == MD_MSUB)  || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) ||
           (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) ||
           (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient
// bit per cycle, WIDTH iterations after the go cycle.
module md_div_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // shifted value and the top bit of the difference acts as the borrow.
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (kill) begin
      run_d = 1'b0;
    end else if (go) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(WIDTH);
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = run_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency multiply and
// multiply-accumulate, iterative divide with sign fix-up, flush cancel.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;

  logic             div_go, div_kill, div_last;
  logic [WIDTH-1:0] abs_a, abs_b, div_quo, div_rem;

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, acc;

  assign abs_a = (is_signed(op) && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_signed(op) && b[WIDTH-1]) ? -b : b;

  // Zero/sign extension to 2*WIDTH lets one truncated product serve both
  // signed and unsigned ops.
  always_comb begin
    a_ext = is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;
    hilo  = {hi_q, lo_q};
    if (!is_acc(op_q))      acc = prod;
    else if (is_sub(op_q))  acc = hilo - prod;
    else                    acc = hilo + prod;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    div_go   = 1'b0;
    div_kill = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end else if (is_mul(op)) begin
            state_d = ST_MUL;
            cnt_d   = 3'(MUL_LAT - 1);
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end else if (is_div(op)) begin
            op_d   = op;
            a_d    = a;
            b_d    = b;
            qneg_d = is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = is_signed(op) && a[WIDTH-1];
            zero_d = (b == '0);
            if (b == '0) begin
              state_d = ST_FIX;
            end else begin
              state_d = ST_DIV;
              div_go  = 1'b1;
            end
          end
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          {hi_d, lo_d} = acc;
          state_d      = ST_IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d  = ST_IDLE;
          div_kill = 1'b1;
        end else if (div_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (zero_q) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = qneg_q ? -div_quo : div_quo;
            hi_d = rneg_q ? -div_rem : div_rem;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    zero_q <= zero_d;
  end

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .go        (div_go),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .kill      (div_kill),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  assign busy  = (state_q != ST_IDLE);
  assign stall = (start && (is_mul(op) || is_div(op)) && !cancel) || busy;
  assign done  = done_q;
  assign dbz   = dbz_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
